// File: rtl/rc_channel_capture_if.sv
// Pin/result bundle for rc_channel_capture: raw PWM pins in, scaled channel
// values and status strobes out.
interface rc_channel_capture_if #(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned VAL_BIT_WIDTH = 8
);
  logic [NUM_CHANNELS-1:0]               pwm_in;
  logic [NUM_CHANNELS*VAL_BIT_WIDTH-1:0] ch_val;
  logic [NUM_CHANNELS-1:0]               ch_update;
  logic [NUM_CHANNELS-1:0]               ch_valid;
  logic                                  all_valid;
  logic                                  frame_strobe;

  modport master (
    output pwm_in,
    input  ch_val, ch_update, ch_valid, all_valid, frame_strobe
  );

  modport slave (
    input  pwm_in,
    output ch_val, ch_update, ch_valid, all_valid, frame_strobe
  );
endinterface

// File: rtl/rc_channel_capture.sv
// N-channel RC PWM receiver: measures each pulse high time in us, validates and
// scales it to a command value, tracks loss of signal and frame completion.
module rc_channel_capture #(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned VAL_BIT_WIDTH = 8,
  parameter int unsigned MIN_PULSE_US  = 1000,
  parameter int unsigned MAX_PULSE_US  = 2000,
  parameter int unsigned MIN_VALID_US  = 800,
  parameter int unsigned MAX_VALID_US  = 2200,
  parameter int unsigned SCALE_MUL     = 262,
  parameter int unsigned SCALE_SHIFT   = 10,
  parameter int unsigned TIMEOUT_US    = 25000,
  parameter int unsigned FAILSAFE_MODE = 1,
  parameter int unsigned FAILSAFE_VAL  = 0
) (
  input  logic                 us_clk,
  input  logic                 resetn,
  rc_channel_capture_if.slave  bus
);

  typedef enum logic [1:0] {ARM, LOW, HIGH, OVERLONG} state_e;

  localparam int unsigned N  = NUM_CHANNELS;
  localparam int unsigned VW = VAL_BIT_WIDTH;
  localparam int unsigned CW = $clog2(MAX_VALID_US + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_US + 1);
  localparam int unsigned MW = $clog2(SCALE_MUL + 1);
  localparam int unsigned PW = CW + MW;

  localparam logic [CW-1:0] MIN_V  = CW'(MIN_VALID_US);
  localparam logic [CW-1:0] MAX_V  = CW'(MAX_VALID_US);
  localparam logic [CW-1:0] MIN_P  = CW'(MIN_PULSE_US);
  localparam logic [CW-1:0] MAX_P  = CW'(MAX_PULSE_US);
  localparam logic [CW-1:0] SPAN   = CW'(MAX_PULSE_US - MIN_PULSE_US);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_US);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_US - 1);
  localparam logic [VW-1:0] VAL_SAT = '1;
  localparam logic [VW-1:0] FS_VAL  = VW'(FAILSAFE_VAL);
  localparam logic [PW-1:0] MUL     = PW'(SCALE_MUL);

  function automatic logic [VW-1:0] scale(input logic [CW-1:0] w);
    logic [CW-1:0] c;
    logic [PW-1:0] p;
    if (w <= MIN_P)      c = '0;
    else if (w >= MAX_P) c = SPAN;
    else                 c = w - MIN_P;
    p = (PW'(c) * MUL) >> SCALE_SHIFT;
    if (p > PW'(VAL_SAT)) return VAL_SAT;
    return VW'(p);
  endfunction

  logic [N-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  state_e        state_q [N];
  state_e        state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic [TW-1:0] to_q    [N];
  logic [TW-1:0] to_d    [N];
  logic [VW-1:0] val_q   [N];
  logic [VW-1:0] val_d   [N];
  logic [N-1:0]  valid_q, valid_d;
  logic [N-1:0]  update_q, update_d;
  logic [N-1:0]  pending_q, pending_d;
  logic          frame_strobe_q, frame_strobe_d;

  always_comb begin
    sync1_d   = bus.pwm_in;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    val_d     = val_q;
    valid_d   = valid_q;
    update_d  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      case (state_q[i])
        ARM:      if (!sync2_q[i]) state_d[i] = LOW;
        LOW: begin
          if (sync2_q[i]) begin
            state_d[i] = HIGH;
            cnt_d[i]   = CW'(1);
          end
        end
        HIGH: begin
          if (!sync2_q[i]) begin
            state_d[i]  = LOW;
            update_d[i] = (cnt_q[i] >= MIN_V) && (cnt_q[i] <= MAX_V);
          end else if (cnt_q[i] == MAX_V) begin
            state_d[i] = OVERLONG;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        OVERLONG: if (!sync2_q[i]) state_d[i] = LOW;
        default:  state_d[i] = ARM;
      endcase

      // Loss is taken on the step into TO_MAX so failsafe loads exactly once.
      if (update_d[i]) begin
        to_d[i]    = '0;
        val_d[i]   = scale(cnt_q[i]);
        valid_d[i] = 1'b1;
      end else if (to_q[i] != TO_MAX) begin
        to_d[i] = to_q[i] + 1'b1;
        if (to_q[i] == TO_LAST) begin
          valid_d[i] = 1'b0;
          if (FAILSAFE_MODE != 0) val_d[i] = FS_VAL;
        end
      end
    end
    frame_strobe_d = &(pending_q | update_d);
    pending_d      = frame_strobe_d ? '0 : (pending_q | update_d);
  end

  // Synchronizers reset high so a pin already high at reset release is seen
  // as an in-progress pulse and ARM waits for its end.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '1;
      sync2_q <= '1;
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= ARM;
        cnt_q[i]   <= '0;
        to_q[i]    <= '0;
        val_q[i]   <= FS_VAL;
      end
      valid_q        <= '0;
      update_q       <= '0;
      pending_q      <= '0;
      frame_strobe_q <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      to_q           <= to_d;
      val_q          <= val_d;
      valid_q        <= valid_d;
      update_q       <= update_d;
      pending_q      <= pending_d;
      frame_strobe_q <= frame_strobe_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_val
    assign bus.ch_val[g*VW +: VW] = val_q[g];
  end

  assign bus.ch_update    = update_q;
  assign bus.ch_valid     = valid_q;
  assign bus.all_valid    = &valid_q;
  assign bus.frame_strobe = frame_strobe_q;

endmodule

// File: tb/tb_rc_channel_capture.sv
// Scoreboard bench for rc_channel_capture: failsafe-mode DUT is fully checked,
// a hold-mode twin shares the pins for the loss-of-signal behaviour.
`timescale 1ns/1ps
module tb_rc_channel_capture;

  typedef struct {
    int     ch;
    int     val;
    longint due;
  } exp_t;

  logic       us_clk;
  logic       resetn;
  logic [3:0] pins;
  longint     cyc;
  int         checks;
  int         failures;
  int         fs_count;
  longint     fs_cyc;
  longint     fall_cyc [4];
  exp_t       sb [$];

  rc_channel_capture_if #(.NUM_CHANNELS(4), .VAL_BIT_WIDTH(8)) bus1 ();
  rc_channel_capture_if #(.NUM_CHANNELS(4), .VAL_BIT_WIDTH(8)) bus0 ();

  assign bus1.pwm_in = pins;
  assign bus0.pwm_in = pins;

  rc_channel_capture #(.FAILSAFE_MODE(1)) dut_fs (
    .us_clk (us_clk),
    .resetn (resetn),
    .bus    (bus1)
  );

  rc_channel_capture #(.FAILSAFE_MODE(0)) dut_hold (
    .us_clk (us_clk),
    .resetn (resetn),
    .bus    (bus0)
  );

  initial us_clk = 1'b0;
  always #5 us_clk = ~us_clk;

  initial cyc = 0;
  always @(posedge us_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drives one high pulse of 'width' cycles; accepted pulses queue their result.
  task automatic pulse(input int ch, input int width, input int expv, input bit acc);
    @(posedge us_clk);
    #1 pins[ch] = 1'b1;
    repeat (width) @(posedge us_clk);
    #1 pins[ch] = 1'b0;
    fall_cyc[ch] = cyc;
    if (acc) sb.push_back('{ch, expv, cyc + 3});
  endtask

  task automatic check_reset_state();
    chk("rst_val",      longint'(bus1.ch_val),    0);
    chk("rst_upd",      longint'(bus1.ch_update), 0);
    chk("rst_valid",    longint'(bus1.ch_valid),  0);
    chk("rst_all",      longint'(bus1.all_valid), 0);
    chk("rst_fs",       longint'(bus1.frame_strobe), 0);
    chk("rst_hold_val", longint'(bus0.ch_val),    0);
  endtask

  always @(negedge us_clk) begin
    int idx;
    if (resetn) begin
      for (int c = 0; c < 4; c++) begin
        if (bus1.ch_update[c]) begin
          idx = -1;
          for (int k = 0; k < sb.size(); k++)
            if (idx < 0 && sb[k].ch == c) idx = k;
          if (idx < 0) begin
            chk("spurious_upd", longint'(bus1.ch_update[c]), 0);
          end else begin
            chk("upd_val",   longint'(bus1.ch_val[c*8 +: 8]), sb[idx].val);
            chk("upd_cyc",   cyc, sb[idx].due);
            chk("upd_valid", longint'(bus1.ch_valid[c]), 1);
            sb.delete(idx);
          end
        end
      end
      if (bus1.frame_strobe) begin
        fs_count++;
        fs_cyc = cyc;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got cycle %0d expected finish earlier", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     sw_w [5];
    int     sw_v [5];
    int     fs0;
    longint u3;
    sw_w = '{900, 1000, 1500, 2000, 2100};
    sw_v = '{0, 0, 127, 255, 255};
    checks = 0; failures = 0; fs_count = 0; fs_cyc = 0;
    pins   = 4'hF;
    resetn = 1'b0;

    repeat (5) @(posedge us_clk);
    #2 check_reset_state();
    @(posedge us_clk);
    #1 resetn = 1'b1;

    // Pins high through reset release: the partial pulse must be ignored.
    repeat (1200) @(posedge us_clk);
    #1 pins = 4'h0;
    repeat (100) @(posedge us_clk);
    pulse(0, 1500, 127, 1);
    repeat (200) @(posedge us_clk);

    for (int i = 0; i < 5; i++) begin
      pulse(0, sw_w[i], sw_v[i], 1);
      repeat (200) @(posedge us_clk);
    end

    pulse(1, 1500, 127, 1);
    repeat (200) @(posedge us_clk);
    pulse(1, 500, 0, 0);
    repeat (200) @(posedge us_clk);
    pulse(1, 2500, 0, 0);
    repeat (200) @(posedge us_clk);
    #1 chk("glitch_hold", longint'(bus1.ch_val[15:8]), 127);
    pulse(1, 1200, 51, 1);
    repeat (200) @(posedge us_clk);

    fs0 = fs_count;
    fork
      pulse(0, 1500, 127, 1);
      begin repeat (50)  @(posedge us_clk); pulse(1, 1500, 127, 1); end
      begin repeat (100) @(posedge us_clk); pulse(2, 1500, 127, 1); end
      begin repeat (150) @(posedge us_clk); pulse(3, 1500, 127, 1); end
    join
    repeat (20) @(posedge us_clk);
    #1 chk("frame_once", fs_count - fs0, 1);
    chk("frame_cyc", fs_cyc, fall_cyc[3] + 3);
    repeat (300) @(posedge us_clk);

    fs0 = fs_count;
    fork
      pulse(0, 1500, 127, 1);
      begin repeat (50)  @(posedge us_clk); pulse(1, 1500, 127, 1); end
      begin repeat (150) @(posedge us_clk); pulse(3, 1500, 127, 1); end
    join
    repeat (20) @(posedge us_clk);
    #1 chk("frame_none", fs_count - fs0, 0);
    u3 = fall_cyc[3] + 3;

    fork
      begin
        while (cyc < u3 + 25200) begin
          fork
            pulse(0, 1500, 127, 1);
            pulse(1, 1500, 127, 1);
            pulse(2, 1500, 127, 1);
          join
          repeat (400) @(posedge us_clk);
        end
      end
      begin
        do @(negedge us_clk); while (cyc < u3 + 24999);
        chk("to_before_valid", longint'(bus1.ch_valid[3]), 1);
        chk("to_before_all",   longint'(bus1.all_valid), 1);
        @(negedge us_clk);
        chk("to_valid",        longint'(bus1.ch_valid[3]), 0);
        chk("to_all",          longint'(bus1.all_valid), 0);
        chk("to_fs_val",       longint'(bus1.ch_val[31:24]), 0);
        chk("to_hold_val",     longint'(bus0.ch_val[31:24]), 127);
        chk("to_hold_valid",   longint'(bus0.ch_valid[3]), 0);
      end
    join

    pulse(3, 1500, 127, 1);
    repeat (10) @(posedge us_clk);
    #1 chk("restore_valid", longint'(bus1.ch_valid[3]), 1);
    chk("restore_all",       longint'(bus1.all_valid), 1);
    chk("restore_hold",      longint'(bus0.ch_valid[3]), 1);
    repeat (200) @(posedge us_clk);

    // Reset in the middle of a ch0 pulse; the remainder must not be measured.
    @(posedge us_clk);
    #1 pins[0] = 1'b1;
    repeat (700) @(posedge us_clk);
    #1 resetn = 1'b0;
    #1 check_reset_state();
    repeat (3) @(posedge us_clk);
    #1 resetn = 1'b1;
    repeat (1000) @(posedge us_clk);
    #1 pins[0] = 1'b0;
    repeat (200) @(posedge us_clk);
    #1 chk("rst_remainder", longint'(bus1.ch_val[7:0]), 0);
    chk("rst_no_valid",     longint'(bus1.ch_valid[0]), 0);
    pulse(0, 1500, 127, 1);
    repeat (20) @(posedge us_clk);
    #1 chk("sb_empty", longint'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc_channel_capture.md
# rc_channel_capture

Parametrised N-channel RC receiver front end that measures the high time of each PWM input in microseconds, validates and scales it to an unsigned command value, and flags per-channel loss of signal. Sits between the RC receiver pins and the angle controller, replacing the fixed four-channel receiver. Adds glitch rejection, configurable failsafe, per-channel update strobes and a frame-complete strobe.

## Interface
- NUM_CHANNELS, 4, number of independent PWM inputs
- VAL_BIT_WIDTH, 8, width of each scaled output value
- MIN_PULSE_US, 1000, pulse width mapped to value 0
- MAX_PULSE_US, 2000, pulse width mapped to full scale
- MIN_VALID_US, 800, shortest accepted pulse
- MAX_VALID_US, 2200, longest accepted pulse
- SCALE_MUL, 262, scaling multiplier
- SCALE_SHIFT, 10, scaling right shift
- TIMEOUT_US, 25000, microseconds without an accepted pulse before the channel is declared lost
- FAILSAFE_MODE, 1, 0 = hold last value on loss; 1 = force FAILSAFE_VAL
- FAILSAFE_VAL, 0, value driven at reset and, in mode 1, on loss
- us_clk  input  1  1 MHz clock; the only clock
- resetn  input  1  asynchronous, active-low reset
- pwm_in  input  NUM_CHANNELS  raw receiver PWM pins (asynchronous)
- ch_val  output  NUM_CHANNELS*VAL_BIT_WIDTH  scaled values; channel i at bits [i*VAL_BIT_WIDTH +: VAL_BIT_WIDTH]
- ch_update  output  NUM_CHANNELS  one-cycle strobe per channel when ch_val changes due to an accepted pulse
- ch_valid  output  NUM_CHANNELS  channel has an accepted pulse within TIMEOUT_US
- all_valid  output  1  AND of ch_valid
- frame_strobe  output  1  one-cycle pulse when every channel has updated since the previous frame_strobe

## Operation
- Each pwm_in bit passes through a 2-flop synchronizer; all logic below uses the synchronized level s[i].
- Per-channel FSM, states ARM, LOW, HIGH, OVERLONG:
  - ARM: entered at reset; go to LOW on first cycle s=0. Prevents measuring a partial pulse.
  - LOW: on s=1 go to HIGH; width counter loads 1.
  - HIGH: counter increments each cycle s=1. On s=0: evaluate width, go to LOW. If the counter would exceed MAX_VALID_US, go to OVERLONG (counter saturates).
  - OVERLONG: wait for s=0, then go to LOW; pulse rejected.
- Width = number of cycles s was 1. Accept iff MIN_VALID_US <= width <= MAX_VALID_US; rejected pulses produce no update and do not restart the timeout.
- Scaling on accept: c = clamp(width, MIN_PULSE_US, MAX_PULSE_US) - MIN_PULSE_US; v = (c*SCALE_MUL) >> SCALE_SHIFT; saturate v to 2^VAL_BIT_WIDTH-1. Defaults: 1000 us -> 0, 1500 -> 127, 2000 -> 255, 2100 -> 255, 900 -> 0.
- Timeout counter per channel: cleared on accept, increments otherwise, saturates at TIMEOUT_US. At TIMEOUT_US, ch_valid drops; mode 1 also loads FAILSAFE_VAL into ch_val (no ch_update). ch_valid rises with the next ch_update.
- Frame tracking: pending bit per channel set on ch_update. frame_strobe fires in the cycle in which all pending bits (including updates in that cycle) are set; pending bits then clear. An update landing in the strobe cycle counts toward the current frame only.
- Channels are fully independent; simultaneous edges on any set of channels are handled in the same cycle.

## Timing
- Reset values: ch_val all FAILSAFE_VAL, ch_update 0, ch_valid 0, all_valid 0, frame_strobe 0, FSMs ARM, counters 0, pending bits 0.
- Pin-to-sync latency 2 cycles. Falling edge seen on s at cycle F (first s=0); ch_val, ch_update, ch_valid updated at F+1 (one registered multiply stage). frame_strobe asserts in the same cycle as the completing ch_update; all_valid asserts at F+1 with the last ch_valid.
- ch_update and frame_strobe are exactly one cycle wide.
- Reset asserted mid-pulse: all state clears immediately; channel re-enters ARM and ignores the in-progress pulse.
- Timeout loss occurs TIMEOUT_US cycles after the last accepted update cycle.

## Test plan
- Reset release with pwm_in held high: no ch_update until a low then a 1500 us pulse; ch_val=127 and ch_update at fall+3 cycles.
- Sweep pulses 900, 1000, 1500, 2000, 2100 us on ch0 -> ch_val 0, 0, 127, 255, 255; each with one ch_update.
- Glitches of 500 us and 2500 us on ch1 -> no ch_update, ch_val unchanged, OVERLONG exits cleanly, next 1200 us pulse -> 51.
- All four channels pulse 1500 us with staggered falls -> frame_strobe once, coincident with the fourth ch_update; second round with ch2 missing -> no frame_strobe.
- Stop ch3 after one accepted pulse: ch_valid[3] and all_valid drop 25000 cycles later; mode 1 ch_val[3]=0, mode 0 holds last value; a new pulse restores ch_valid.
- Assert resetn mid-pulse on ch0 -> outputs return to reset values immediately; pulse remainder produces no update.
